// File: rtl/ttl_pkg.sv
// Shared types and defaults for the multi-channel TTL edge prescaler.
// Edge-mode encodings are the per-channel 2-bit edge_mode fields.
package ttl_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_t;

  localparam int DEF_CH          = 4;
  localparam int DEF_DIV_W       = 8;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/ttl_edge_chan.sv
// One prescaler channel: synchroniser, edge qualify, divide-by-N,
// saturating pulse counter with sticky overflow.
import ttl_pkg::*;

module ttl_edge_chan #(
  parameter int DIV_W       = DEF_DIV_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ip,
  input  logic             en,
  input  edge_mode_t       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             clr,
  output logic             op,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   prev;
  logic                   rise;
  logic                   fall;
  logic                   hit;
  logic                   qual;
  logic                   fire;
  logic                   cnt_max;
  logic                   cnt_near;
  logic [DIV_W-1:0]       ectr;
  logic [DIV_W-1:0]       eff_div;
  logic [DIV_W:0]         ectr_inc;

  assign s = sync[SYNC_STAGES-1];

  // prev tracks the line every cycle so enabling never fakes an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ip};
      prev <= s;
    end
  end

  assign rise = s & ~prev;
  assign fall = ~s & prev;

  always_comb begin
    hit = 1'b0;
    unique case (mode)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      EDGE_OFF:  hit = 1'b0;
    endcase
  end

  assign qual     = en & hit;
  assign eff_div  = (div == '0) ? DIV_W'(1) : div;
  assign ectr_inc = {1'b0, ectr} + 1'b1;
  assign fire     = qual && (ectr_inc >= {1'b0, eff_div});

  assign cnt_max  = &cnt;
  assign cnt_near = &cnt[CNT_W-1:1] & ~cnt[0];

  // ovf is raised as the count reaches all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ectr <= '0;
      op   <= 1'b0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else if (clr) begin
      ectr <= '0;
      op   <= 1'b0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      op <= fire;
      if (qual) begin
        ectr <= fire ? '0 : ectr_inc[DIV_W-1:0];
      end
      if (fire) begin
        if (cnt_max) begin
          ovf <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
          if (cnt_near) ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ttl_edge_prescaler.sv
// Multi-channel TTL edge prescaler and event counter.
// Channels share only div and clr.
import ttl_pkg::*;

module ttl_edge_prescaler #(
  parameter int CH          = DEF_CH,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CH-1:0]       ip,
  input  logic [CH-1:0]       en,
  input  logic [2*CH-1:0]     edge_mode,
  input  logic [DIV_W-1:0]    div,
  input  logic                clr,
  output logic [CH-1:0]       op,
  output logic [CH*CNT_W-1:0] cnt,
  output logic [CH-1:0]       ovf
);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    ttl_edge_chan #(
      .DIV_W       (DIV_W),
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .ip    (ip[i]),
      .en    (en[i]),
      .mode  (edge_mode_t'(edge_mode[2*i +: 2])),
      .div   (div),
      .clr   (clr),
      .op    (op[i]),
      .cnt   (cnt[i*CNT_W +: CNT_W]),
      .ovf   (ovf[i])
    );
  end

endmodule
